// File: rtl/hazard_scoreboard_if.sv
// Decode-slot hazard interface between the pipeline control (master) and the scoreboard (slave).
interface hazard_scoreboard_if #(
    parameter int unsigned RAW   = 5,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned FW = $clog2(DEPTH + 2);

    logic             dec_valid;
    logic [RAW-1:0]   dec_rs1;
    logic [RAW-1:0]   dec_rs2;
    logic [RAW-1:0]   dec_rd;
    logic             dec_use_rs1;
    logic             dec_use_rs2;
    logic             dec_regwrite;
    logic             dec_is_load;
    logic             flush_req;
    logic             stall_fd;
    logic             flush_d;
    logic             bubble_e;
    logic [FW-1:0]    fwd1_e;
    logic [FW-1:0]    fwd2_e;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2,
               dec_regwrite, dec_is_load, flush_req,
        input  stall_fd, flush_d, bubble_e, fwd1_e, fwd2_e, stall_cnt, flush_cnt
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2,
               dec_regwrite, dec_is_load, flush_req,
        output stall_fd, flush_d, bubble_e, fwd1_e, fwd2_e, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks in-flight destination registers, raises load-use stalls,
// and selects the forwarding source for each operand of the instruction entering stage 1.
module hazard_scoreboard #(
    parameter int unsigned RAW        = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned ALU_READY  = 2,
    parameter int unsigned LOAD_READY = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_scoreboard_if.slave hz
);
    localparam int unsigned FW = $clog2(DEPTH + 2);

    typedef struct packed {
        logic           valid;
        logic [RAW-1:0] rd;
        logic           regwrite;
        logic           is_load;
    } stage_t;

    stage_t [DEPTH:1] st;
    logic   [FW-1:0]  fwd1_q;
    logic   [FW-1:0]  fwd2_q;
    logic   [FW-1:0]  sel1;
    logic   [FW-1:0]  sel2;
    logic             haz1;
    logic             haz2;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Returns {stall, select}; scanning from stage 1 upward lets the youngest producer win.
    function automatic logic [FW:0] lookup(
        input stage_t [DEPTH:1] stg,
        input logic [RAW-1:0]   rs,
        input logic             rd_used
    );
        logic        found;
        logic [FW:0] r;
        found = 1'b0;
        r     = '0;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            if (!found && rd_used && stg[k].valid && stg[k].regwrite &&
                stg[k].rd != '0 && stg[k].rd == rs) begin
                found       = 1'b1;
                r[FW-1:0]   = FW'(k + 1);
                r[FW]       = (k + 1) < (stg[k].is_load ? LOAD_READY : ALU_READY);
            end
        end
        return r;
    endfunction

    always_comb begin
        {haz1, sel1} = lookup(st, hz.dec_rs1, hz.dec_use_rs1 & hz.dec_valid);
        {haz2, sel2} = lookup(st, hz.dec_rs2, hz.dec_use_rs2 & hz.dec_valid);
        stall        = (haz1 | haz2) & ~hz.flush_req;
        bubble       = stall | hz.flush_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st          <= '0;
            fwd1_q      <= '0;
            fwd2_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            st[DEPTH:2] <= st[DEPTH-1:1];
            if (bubble) begin
                st[1]  <= '0;
                fwd1_q <= '0;
                fwd2_q <= '0;
            end else begin
                st[1]  <= '{valid:    hz.dec_valid,
                            rd:       hz.dec_rd,
                            regwrite: hz.dec_regwrite & hz.dec_valid,
                            is_load:  hz.dec_is_load & hz.dec_valid};
                fwd1_q <= sel1;
                fwd2_q <= sel2;
            end
            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (hz.flush_req && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_fd  = stall;
    assign hz.flush_d   = hz.flush_req;
    assign hz.bubble_e  = bubble;
    assign hz.fwd1_e    = fwd1_q;
    assign hz.fwd2_e    = fwd2_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, counter/reset sequences, and a random
// run checked against a producer-distance reference model.
module tb_hazard_scoreboard;
    localparam int RAW        = 5;
    localparam int DEPTH      = 3;
    localparam int ALU_READY  = 2;
    localparam int LOAD_READY = 3;
    localparam int MAX_CNT    = 65535;
    localparam int MAX_SAT    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.RAW(RAW), .DEPTH(DEPTH), .CNT_W(16)) hz_if ();
    hazard_scoreboard_if #(.RAW(RAW), .DEPTH(DEPTH), .CNT_W(2))  sat_if ();

    assign sat_if.dec_valid    = hz_if.dec_valid;
    assign sat_if.dec_rs1      = hz_if.dec_rs1;
    assign sat_if.dec_rs2      = hz_if.dec_rs2;
    assign sat_if.dec_rd       = hz_if.dec_rd;
    assign sat_if.dec_use_rs1  = hz_if.dec_use_rs1;
    assign sat_if.dec_use_rs2  = hz_if.dec_use_rs2;
    assign sat_if.dec_regwrite = hz_if.dec_regwrite;
    assign sat_if.dec_is_load  = hz_if.dec_is_load;
    assign sat_if.flush_req    = hz_if.flush_req;

    hazard_scoreboard #(.RAW(RAW), .DEPTH(DEPTH), .ALU_READY(ALU_READY),
                        .LOAD_READY(LOAD_READY), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if.slave)
    );

    hazard_scoreboard #(.RAW(RAW), .DEPTH(DEPTH), .ALU_READY(ALU_READY),
                        .LOAD_READY(LOAD_READY), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .hz  (sat_if.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit u1, input bit u2, input bit rw, input bit ld, input bit fl);
        hz_if.dec_valid    = v;
        hz_if.dec_rs1      = RAW'(rs1);
        hz_if.dec_rs2      = RAW'(rs2);
        hz_if.dec_rd       = RAW'(rd);
        hz_if.dec_use_rs1  = u1;
        hz_if.dec_use_rs2  = u2;
        hz_if.dec_regwrite = rw;
        hz_if.dec_is_load  = ld;
        hz_if.flush_req    = fl;
    endtask

    // Reference model: what each of the last DEPTH issue slots wrote, index = distance.
    bit m_v  [1:DEPTH];
    int m_rd [1:DEPTH];
    bit m_rw [1:DEPTH];
    bit m_ld [1:DEPTH];
    int m_f1, m_f2, m_sc, m_fc, m_ssc, m_sfc;

    task automatic model_reset();
        for (int d = 1; d <= DEPTH; d++) begin
            m_v[d] = 0; m_rd[d] = 0; m_rw[d] = 0; m_ld[d] = 0;
        end
        m_f1 = 0; m_f2 = 0; m_sc = 0; m_fc = 0; m_ssc = 0; m_sfc = 0;
    endtask

    function automatic void producer(input int rs, input bit used, output int sel, output bit stl);
        sel = 0;
        stl = 0;
        if (!used) return;
        for (int d = 1; d <= DEPTH; d++) begin
            if (m_v[d] && m_rw[d] && m_rd[d] != 0 && m_rd[d] == rs) begin
                sel = d + 1;
                stl = (d + 1) < (m_ld[d] ? LOAD_READY : ALU_READY);
                return;
            end
        end
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, " stall_fd"},  32'(hz_if.stall_fd),  0);
        chk({tag, " flush_d"},   32'(hz_if.flush_d),   0);
        chk({tag, " bubble_e"},  32'(hz_if.bubble_e),  0);
        chk({tag, " fwd1_e"},    32'(hz_if.fwd1_e),    0);
        chk({tag, " fwd2_e"},    32'(hz_if.fwd2_e),    0);
        chk({tag, " stall_cnt"}, 32'(hz_if.stall_cnt), 0);
        chk({tag, " flush_cnt"}, 32'(hz_if.flush_cnt), 0);
        chk({tag, " sat stall_cnt"}, 32'(sat_if.stall_cnt), 0);
    endtask

    task automatic reset_dut();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;
    endtask

    typedef struct {
        bit v; int rs1; int rs2; int rd; bit u1; bit u2; bit rw; bit ld; bit fl;
        bit e_stall; bit e_fd; bit e_bub; int e_f1; int e_f2; int e_sc; int e_fc;
    } vec_t;

    vec_t tbl[22];

    initial begin
        //          v rs1 rs2 rd u1 u2 rw ld fl | stall fd bub f1 f2 sc fc
        tbl[0]  = '{1, 0, 0, 5, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0}; // add x5
        tbl[1]  = '{1, 5, 0, 6, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0}; // add x6,x5,x0
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 5, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0}; // lw x5
        tbl[4]  = '{1, 5, 0, 7, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0, 0, 0}; // load-use stall
        tbl[5]  = '{1, 5, 0, 7, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0}; // held, released
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3, 0, 1, 0};
        tbl[7]  = '{1, 0, 0, 8, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0}; // add x8
        tbl[8]  = '{1, 7, 8, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0}; // x7 dist 3, x8 dist 1
        tbl[9]  = '{1, 8, 7, 0, 1, 1, 0, 0, 0,  0, 0, 0, 4, 2, 1, 0}; // x8 dist 2, x7 retired
        tbl[10] = '{1, 0, 0, 9, 0, 0, 1, 0, 0,  0, 0, 0, 3, 0, 1, 0}; // add x9 (a)
        tbl[11] = '{1, 0, 0, 9, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0}; // add x9 (b)
        tbl[12] = '{1, 9, 9, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0}; // younger x9 wins
        tbl[13] = '{1, 9, 0, 0, 1, 1, 1, 0, 0,  0, 0, 0, 2, 2, 1, 0}; // writer to x0
        tbl[14] = '{1, 9, 0, 4, 1, 0, 0, 0, 0,  0, 0, 0, 3, 0, 1, 0}; // non-writer rd=x4
        tbl[15] = '{1, 4, 0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 4, 0, 1, 0}; // read x4 and x0
        tbl[16] = '{1, 0, 0, 3, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 0}; // lw x3
        tbl[17] = '{1, 3, 0, 0, 1, 0, 0, 0, 1,  0, 1, 1, 0, 0, 1, 0}; // flush beats stall
        tbl[18] = '{0, 3, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1}; // invalid decode
        tbl[19] = '{1, 0, 0, 2, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1, 1}; // lw x2
        tbl[20] = '{0, 2, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1}; // invalid: no stall
        tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1};
    end

    initial begin
        int sel1, sel2;
        bit stl1, stl2, e_stall, e_bub;
        bit v, u1, u2, rw, ld, fl;
        int rs1, rs2, rd;

        rst = 1'b0;
        reset_dut();

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2,
                  tbl[i].rw, tbl[i].ld, tbl[i].fl);
            #1;
            chk($sformatf("vec%0d stall_fd", i),  32'(hz_if.stall_fd),  32'(tbl[i].e_stall));
            chk($sformatf("vec%0d flush_d", i),   32'(hz_if.flush_d),   32'(tbl[i].e_fd));
            chk($sformatf("vec%0d bubble_e", i),  32'(hz_if.bubble_e),  32'(tbl[i].e_bub));
            chk($sformatf("vec%0d fwd1_e", i),    32'(hz_if.fwd1_e),    32'(tbl[i].e_f1));
            chk($sformatf("vec%0d fwd2_e", i),    32'(hz_if.fwd2_e),    32'(tbl[i].e_f2));
            chk($sformatf("vec%0d stall_cnt", i), 32'(hz_if.stall_cnt), 32'(tbl[i].e_sc));
            chk($sformatf("vec%0d flush_cnt", i), 32'(hz_if.flush_cnt), 32'(tbl[i].e_fc));
            chk($sformatf("vec%0d sat stall_cnt", i), 32'(sat_if.stall_cnt), 32'(tbl[i].e_sc));
        end

        // A load that reads its own destination stalls on every second cycle.
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 5, 0, 5, 1, 0, 1, 1, 0);
            #1;
            chk($sformatf("sat seq%0d stall_fd", i), 32'(hz_if.stall_fd), 32'(i % 2));
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sat main stall_cnt", 32'(hz_if.stall_cnt), 5);
        chk("sat narrow stall_cnt", 32'(sat_if.stall_cnt), 3);

        // Reset in the middle of a pending load-use stall.
        @(negedge clk);
        drive(1, 0, 0, 6, 0, 0, 1, 1, 0);
        @(negedge clk);
        drive(1, 6, 0, 0, 1, 0, 0, 0, 0);
        #1;
        chk("midrst pre stall_fd", 32'(hz_if.stall_fd), 1);
        #1;
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst release stall_fd", 32'(hz_if.stall_fd), 0);
        chk("midrst release bubble_e", 32'(hz_if.bubble_e), 0);

        // Random run against the reference model.
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            v   = ($urandom_range(0, 9) < 8);
            rs1 = $urandom_range(0, 3);
            rs2 = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            u1  = ($urandom_range(0, 9) < 8);
            u2  = ($urandom_range(0, 9) < 6);
            rw  = ($urandom_range(0, 9) < 7);
            ld  = ($urandom_range(0, 9) < 4);
            fl  = ($urandom_range(0, 9) < 1);
            drive(v, rs1, rs2, rd, u1, u2, rw, ld, fl);
            #1;
            producer(rs1, u1 && v, sel1, stl1);
            producer(rs2, u2 && v, sel2, stl2);
            e_stall = (stl1 || stl2) && !fl;
            e_bub   = e_stall || fl;
            chk("rnd stall_fd",  32'(hz_if.stall_fd),  32'(e_stall));
            chk("rnd flush_d",   32'(hz_if.flush_d),   32'(fl));
            chk("rnd bubble_e",  32'(hz_if.bubble_e),  32'(e_bub));
            chk("rnd fwd1_e",    32'(hz_if.fwd1_e),    32'(m_f1));
            chk("rnd fwd2_e",    32'(hz_if.fwd2_e),    32'(m_f2));
            chk("rnd stall_cnt", 32'(hz_if.stall_cnt), 32'(m_sc));
            chk("rnd flush_cnt", 32'(hz_if.flush_cnt), 32'(m_fc));
            chk("rnd sat stall_cnt", 32'(sat_if.stall_cnt), 32'(m_ssc));
            chk("rnd sat flush_cnt", 32'(sat_if.flush_cnt), 32'(m_sfc));

            for (int d = DEPTH; d >= 2; d--) begin
                m_v[d] = m_v[d-1]; m_rd[d] = m_rd[d-1]; m_rw[d] = m_rw[d-1]; m_ld[d] = m_ld[d-1];
            end
            if (e_bub) begin
                m_v[1] = 0; m_rd[1] = 0; m_rw[1] = 0; m_ld[1] = 0;
                m_f1 = 0; m_f2 = 0;
            end else begin
                m_v[1] = v; m_rd[1] = rd; m_rw[1] = rw && v; m_ld[1] = ld && v;
                m_f1 = sel1; m_f2 = sel2;
            end
            if (e_stall) begin
                m_sc  = (m_sc  < MAX_CNT) ? m_sc + 1  : MAX_CNT;
                m_ssc = (m_ssc < MAX_SAT) ? m_ssc + 1 : MAX_SAT;
            end
            if (fl) begin
                m_fc  = (m_fc  < MAX_CNT) ? m_fc + 1  : MAX_CNT;
                m_sfc = (m_sfc < MAX_SAT) ? m_sfc + 1 : MAX_SAT;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
  - RAW, 5: register address width.
  - DEPTH, 3: number of in-flight stages after decode; stage 1 = E, stage DEPTH = W.
  - ALU_READY, 2: first stage holding a non-load result.
  - LOAD_READY, 3: first stage holding load data.
  - CNT_W, 16: event counter width.
REQ-002 Parameter legality SHALL be DEPTH>=2 and 1<=ALU_READY<=LOAD_READY<=DEPTH; FW SHALL be defined as clog2(DEPTH+2).
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1: single clock.
  - rst, in, 1: reset, asynchronous and active-low.
  - dec_valid, in, 1: decode slot holds an instruction.
  - dec_rs1, dec_rs2, dec_rd, in, RAW each: decode register addresses.
  - dec_use_rs1, dec_use_rs2, in, 1 each: operand actually read.
  - dec_regwrite, dec_is_load, in, 1 each: decode control.
  - flush_req, in, 1: taken branch/jump resolved in stage 1.
  - stall_fd, out, 1: hold PC and F/D register.
  - flush_d, out, 1: clear F/D register.
  - bubble_e, out, 1: load a bubble into stage 1.
  - fwd1_e, fwd2_e, out, FW each: operand source for the instruction in stage 1.
  - stall_cnt, flush_cnt, out, CNT_W each: event counters.

Function
REQ-004 The block SHALL hold per-stage records {valid, rd, regwrite, is_load} for stages 1..DEPTH; every clock edge stage k moves to k+1 and stage DEPTH retires, with no back-pressure.
REQ-005 A stage k SHALL "match" operand rsN iff valid & regwrite & rd!=0 & rd==rsN & dec_use_rsN & dec_valid.
REQ-006 For each operand the youngest (lowest k) matching stage SHALL alone determine hazard and forwarding; older matches are ignored.
REQ-007 A youngest match at stage k SHALL cause a stall iff k+1 < (is_load ? LOAD_READY : ALU_READY).
REQ-008 stall_fd SHALL be combinational, equal to (operand-1 stall | operand-2 stall) & ~flush_req.
REQ-009 flush_d SHALL equal flush_req, and bubble_e SHALL equal stall_fd | flush_req, both combinational.
REQ-010 The computed forward select SHALL be k+1 for a youngest match at stage k, where DEPTH+1 means the datapath's one-entry retired-result register; it SHALL be 0 (register file) when no match exists.
REQ-011 On an edge with bubble_e=1, stage 1 SHALL become invalid and fwd1_e/fwd2_e SHALL become 0.
REQ-012 On an edge with bubble_e=0, stage 1 SHALL load the decode fields with regwrite and is_load ANDed with dec_valid, and fwd1_e/fwd2_e SHALL load the computed selects.
REQ-013 flush_req SHALL take priority over any stall in the same cycle; the stalled decode instruction is squashed rather than held.
REQ-014 stall_cnt SHALL increment on each edge where stall_fd=1, and flush_cnt on each edge where flush_req=1; both SHALL saturate at all-ones with no wrap.
REQ-015 With dec_valid=0 the block SHALL produce stall_fd=0 and computed selects of 0.

Reset
REQ-016 On rst=0 the block SHALL asynchronously clear all stage records to invalid and fwd1_e, fwd2_e, stall_cnt and flush_cnt to 0; combinational outputs then read 0 while flush_req=0.
REQ-017 Reset asserted mid-stall SHALL discard the pending stall, and the first cycle after release SHALL see no hazard.

Verification (defaults unless stated)
REQ-018 ALU back-to-back: add x5 then add x6,x5,x0 -> stall_fd=0, and next cycle fwd1_e=2.
REQ-019 Load-use: lw x5 then add x6,x5,x0 -> stall_fd=1 and bubble_e=1 for exactly one cycle, then fwd1_e=3, stall_cnt=1.
REQ-020 Distance: producer two instructions ahead -> fwd=3; producer three ahead -> fwd=4; four ahead -> fwd=0; two matching producers -> younger one selected.
REQ-021 x0 and non-writers: writer to x0, or regwrite=0 with the same rd -> no stall, fwd=0.
REQ-022 Flush vs stall: flush_req=1 with a load-use hazard present -> stall_fd=0, flush_d=1, bubble_e=1, flush_cnt increments, stall_cnt unchanged.
REQ-023 Saturation and reset: with CNT_W=2, five stalls -> stall_cnt=3; rst=0 mid-stall -> all outputs 0 immediately.
